// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and SRAM bus widths for the MEM-stage SRAM controller.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    // One address bit selects the half-word, the rest is the 32-bit word index.
    localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase wait counter: counts cycles spent in one half-word access phase.
// Latency: last asserts combinationally when the count reaches COUNT-1.
// Backpressure: none; clr has priority over en, so a phase always restarts at 0.
module sram_wait_counter #(
    parameter int COUNT = 2,
    parameter int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(COUNT - 1);

    logic [CNT_W-1:0] count;

    // Restart on reset or phase entry, otherwise advance while the phase is active.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage word access over a 16-bit asynchronous SRAM, low half then high half.
// Latency: 2*WAIT_CYCLES+1 stall cycles per access; optional zero-stall read hit with SRAM_READ_BYPASS_EN.
// Backpressure: ready is low while an access is pending; the pipeline freezes on ~ready.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);

    state_t                state;
    logic                  op_write;   // latched on start so a dropped request still completes
    logic                  cnt_last;
    logic                  active;
    logic                  start;
    logic                  hit;
    logic [WORD_IDX_W-1:0] word_idx;
    logic                  unused_addr_bits;

    assign word_idx         = address[18:2];
    assign unused_addr_bits = ^{address[31:19], address[1:0]};
    assign active           = (state == LOW) || (state == HIGH);

`ifdef SRAM_READ_BYPASS_EN
    logic [WORD_IDX_W-1:0] last_idx;
    logic                  last_valid;

    // A read of the most recently read word is served from read_data without touching SRAM.
    assign hit = rd_en && !wr_en && last_valid && (word_idx == last_idx);
`else
    assign hit = 1'b0;
`endif

    assign start = (state == IDLE) && (wr_en || rd_en) && !hit;
    assign ready = (state == DONE) || ((state == IDLE) && !start);

    sram_wait_counter #(
        .COUNT (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (!active || cnt_last),
        .en   (active),
        .last (cnt_last)
    );

    // Sequencer: IDLE -> LOW -> HIGH -> DONE -> IDLE, capturing read halves on each phase's last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            read_data <= '0;
`ifdef SRAM_READ_BYPASS_EN
            last_valid <= 1'b0;
            last_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOW;
                        op_write <= wr_en;
                    end
                end
                LOW: begin
                    if (cnt_last) begin
                        state <= HIGH;
                        if (!op_write) begin
                            read_data[SRAM_DATA_W-1:0] <= sram_dq_in;
                        end
                    end
                end
                HIGH: begin
                    if (cnt_last) begin
                        state <= DONE;
                        if (!op_write) begin
                            read_data[31:SRAM_DATA_W] <= sram_dq_in;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef SRAM_READ_BYPASS_EN
                    if (!op_write) begin
                        last_valid <= 1'b1;
                        last_idx   <= word_idx;
                    end else if (last_valid && (word_idx == last_idx)) begin
                        // Keep the buffered word coherent with the SRAM contents.
                        read_data <= write_data;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pin decode: half select follows the phase, the strobe is released on each phase's last cycle for hold.
    always_comb begin
        sram_addr   = {word_idx, (state == HIGH)};
        sram_dq_oe  = active && op_write;
        sram_we_n   = !(active && op_write && !cnt_last);
        sram_dq_out = '0;
        if (active && op_write) begin
            sram_dq_out = (state == HIGH) ? write_data[31:SRAM_DATA_W] : write_data[SRAM_DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM.
// Latency: checks 2W+1 stall cycles per miss and zero stall on bypass hits.
// Backpressure: transactions are held until ready is seen high.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic [15:0] mem [0:255];
    logic [17:0] strobe_addr [0:7];
    logic [15:0] strobe_dat  [0:7];
    int          we_cnt = 0;
    int          oe_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    sram_controller #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (sram_we_n == 1'b0) begin
            mem[sram_addr[7:0]]      <= sram_dq_out;
            strobe_addr[we_cnt[2:0]] <= sram_addr;
            strobe_dat[we_cnt[2:0]]  <= sram_dq_out;
            we_cnt                   <= we_cnt + 1;
        end
        if (sram_dq_oe == 1'b1) begin
            oe_cnt <= oe_cnt + 1;
        end
    end

    // Entered and left just after a rising edge.
    task automatic do_txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rdat);
        bit done;
        wr_en      = wr;
        rd_en      = rd;
        address    = a;
        write_data = d;
        stalls     = 0;
        done       = 1'b0;
        rdat       = 32'hxxxx_xxxx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                done = 1'b1;
                rdat = read_data;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL txn_timeout addr=%h ready never rose within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h8; write_data = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", sram_dq_oe); end
        n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_read_data got %h want 0", read_data); end
        n_cmp++; if (sram_dq_out !== 16'h0) begin n_bad++; $display("FAIL reset_dq_out got %h want 0", sram_dq_out); end
        n_cmp++; if (sram_addr !== 18'h4) begin n_bad++; $display("FAIL reset_addr got %h want 00004", sram_addr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        int st; logic [31:0] rd; int we0; int oe0;
        we0 = we_cnt; oe0 = oe_cnt;
        do_txn(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL write_stall got %0d want 5", st); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL write_rd_unchanged got %h want 0", rd); end
        n_cmp++; if (we_cnt - we0 !== 2) begin n_bad++; $display("FAIL write_strobes got %0d want 2", we_cnt - we0); end
        n_cmp++; if (oe_cnt - oe0 !== 4) begin n_bad++; $display("FAIL write_oe_cycles got %0d want 4", oe_cnt - oe0); end
        n_cmp++; if (strobe_addr[we0 % 8] !== 18'h4) begin n_bad++; $display("FAIL write_lo_addr got %h want 00004", strobe_addr[we0 % 8]); end
        n_cmp++; if (strobe_dat[we0 % 8] !== 16'hBEEF) begin n_bad++; $display("FAIL write_lo_data got %h want beef", strobe_dat[we0 % 8]); end
        n_cmp++; if (strobe_addr[(we0 + 1) % 8] !== 18'h5) begin n_bad++; $display("FAIL write_hi_addr got %h want 00005", strobe_addr[(we0 + 1) % 8]); end
        n_cmp++; if (strobe_dat[(we0 + 1) % 8] !== 16'hDEAD) begin n_bad++; $display("FAIL write_hi_data got %h want dead", strobe_dat[(we0 + 1) % 8]); end
    endtask

    task automatic test_read();
        int st; logic [31:0] rd;
        do_txn(1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL read_stall got %0d want 5", st); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data got %h want deadbeef", rd); end
        do_txn(1'b1, 1'b0, 32'h1C, 32'hA5A55A5A, st, rd);
        do_txn(1'b0, 1'b1, 32'h1C, 32'h0, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL read2_stall got %0d want 5", st); end
        n_cmp++; if (rd !== 32'hA5A55A5A) begin n_bad++; $display("FAIL read2_data got %h want a5a55a5a", rd); end
    endtask

    task automatic test_priority();
        int st; logic [31:0] rd;
        do_txn(1'b1, 1'b1, 32'h8, 32'h12345678, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL prio_stall got %0d want 5", st); end
        n_cmp++; if (rd !== 32'hA5A55A5A) begin n_bad++; $display("FAIL prio_rd_unchanged got %h want a5a55a5a", rd); end
        n_cmp++; if (mem[4] !== 16'h5678) begin n_bad++; $display("FAIL prio_mem_lo got %h want 5678", mem[4]); end
        n_cmp++; if (mem[5] !== 16'h1234) begin n_bad++; $display("FAIL prio_mem_hi got %h want 1234", mem[5]); end
        @(negedge clk);
        n_cmp++; if (read_data !== 32'hA5A55A5A) begin n_bad++; $display("FAIL prio_rd_after got %h want a5a55a5a", read_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int st; logic [31:0] rd;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'h20; write_data = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (sram_addr !== 18'h11) begin n_bad++; $display("FAIL midrst_high_addr got %h want 00011", sram_addr); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", ready); end
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", ready); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL midrst_we_n got %b want 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_oe got %b want 0", sram_dq_oe); end
        n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL midrst_read_data got %h want 0", read_data); end
        @(posedge clk);
        #1;
        do_txn(1'b1, 1'b0, 32'h20, 32'h0BADF00D, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL midrst_reissue_stall got %0d want 5", st); end
        n_cmp++; if (mem[16] !== 16'hF00D) begin n_bad++; $display("FAIL midrst_mem_lo got %h want f00d", mem[16]); end
        n_cmp++; if (mem[17] !== 16'h0BAD) begin n_bad++; $display("FAIL midrst_mem_hi got %h want 0bad", mem[17]); end
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] rd;
        do_txn(1'b0, 1'b1, 32'h20, 32'h0, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL b2b_first_stall got %0d want 5", st); end
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL b2b_first_data got %h want 0badf00d", rd); end
        do_txn(1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL b2b_second_stall got %0d want 5", st); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL b2b_second_data got %h want 12345678", rd); end
    endtask

    task automatic test_bypass();
        int st; logic [31:0] rd; int we0; int oe0;
`ifdef SRAM_READ_BYPASS_EN
        localparam int HIT_STALL = 0;
`else
        localparam int HIT_STALL = 5;
`endif
        we0 = we_cnt; oe0 = oe_cnt;
        do_txn(1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        n_cmp++; if (st !== HIT_STALL) begin n_bad++; $display("FAIL repeat_read_stall got %0d want %0d", st, HIT_STALL); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL repeat_read_data got %h want 12345678", rd); end
        n_cmp++; if (we_cnt - we0 !== 0) begin n_bad++; $display("FAIL repeat_read_strobes got %0d want 0", we_cnt - we0); end
        n_cmp++; if (oe_cnt - oe0 !== 0) begin n_bad++; $display("FAIL repeat_read_oe got %0d want 0", oe_cnt - oe0); end
        do_txn(1'b1, 1'b0, 32'h8, 32'hCAFEF00D, st, rd);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL wt_write_stall got %0d want 5", st); end
        do_txn(1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        n_cmp++; if (st !== HIT_STALL) begin n_bad++; $display("FAIL wt_read_stall got %0d want %0d", st, HIT_STALL); end
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wt_read_data got %h want cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_reset_mid_op();
        test_back_to_back();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
